// File: rtl/up_cnt_pkg.sv
// -----------------------------------------------------------------------------
// up_cnt_pkg
// Shared definitions for the up-counter sequencing controller.
//   state_t          : 2-bit FSM state code
//   ST_IDLE..ST_DONE : state encodings, kept as plain constants so older
//                      tools and netlist viewers show stable values
//   MODE_ONESHOT     : stop in DONE after reaching the terminal count
//   MODE_PERIODIC    : wrap to 0 after reaching the terminal count
// -----------------------------------------------------------------------------
package up_cnt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_core.sv
// -----------------------------------------------------------------------------
// cnt_core
// WIDTH-bit synchronous up counter.
//   clk   : clock, posedge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear to 0, wins over en
//   en    : increment by one when set
//   count : current value
// -----------------------------------------------------------------------------
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/up_counter_ctrl.sv
// -----------------------------------------------------------------------------
// up_counter_ctrl
// Sequencing controller around cnt_core: latches terminal count and mode on
// start, runs/pauses/stops the counter, and reports completion.
//   clk      : clock, posedge
//   rst      : synchronous active-high reset
//   start    : pulse, begin a run from IDLE or DONE
//   stop     : pulse, abort to IDLE and clear the count (beats start)
//   run_en   : level, 1 = count, 0 = pause while running
//   mode     : 0 one-shot, 1 periodic; sampled with start
//   cfg_term : terminal count; sampled with start
//   irq_clr  : pulse, clear irq
//   count    : current counter value
//   busy     : state is RUN or HOLD
//   wrap     : one-cycle pulse when a periodic run wraps to 0
//   done     : one-cycle pulse on one-shot completion
//   irq      : sticky, set by wrap or done
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | stopped, count 0, waiting for start
// RUN   | counting while run_en=1
// HOLD  | paused by run_en=0, count frozen
// DONE  | one-shot finished, count holds term, start restarts
// -----------------------------------------------------------------------------
module up_counter_ctrl
    import up_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             run_en,
    input  logic             mode,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             irq
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] term_q;
    logic             mode_q;

    logic at_term;
    logic start_acc;
    logic term_hit;
    logic wrap_evt;
    logic done_evt;
    logic cnt_clr;
    logic cnt_en;

    assign at_term   = (count == term_q);
    assign start_acc = start && !stop && (state == ST_IDLE || state == ST_DONE);
    // A counting cycle that lands on term; stop suppresses any pulse.
    assign term_hit  = (state == ST_RUN) && run_en && at_term && !stop;
    assign wrap_evt  = term_hit && (mode_q == MODE_PERIODIC);
    assign done_evt  = term_hit && (mode_q == MODE_ONESHOT);

    assign cnt_clr = stop || start_acc || wrap_evt;
    assign cnt_en  = (state == ST_RUN) && run_en && !at_term;

    assign busy = (state == ST_RUN) || (state == ST_HOLD);

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (!run_en) begin
                        state_nxt = ST_HOLD;
                    end else if (done_evt) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_HOLD: if (run_en) state_nxt = ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            term_q <= '0;
            mode_q <= MODE_ONESHOT;
            wrap   <= 1'b0;
            done   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                term_q <= cfg_term;
                mode_q <= mode;
            end
            wrap <= wrap_evt;
            done <= done_evt;
            // A new event beats a clear arriving in the same cycle.
            irq  <= wrap_evt || done_evt || (irq && !irq_clr);
        end
    end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed bench for up_counter_ctrl. Inputs change on the falling edge; each
// cyc() call queues the outputs expected right after the next rising edge, and
// a monitor pops and compares one entry shortly after every rising edge.
module tb_up_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       run_en = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] cfg_term = 4'd0;
    logic       irq_clr = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       irq;

    typedef struct {
        string      tag;
        logic [7:0] val;   // {count, busy, wrap, done, irq}
    } exp_t;

    exp_t  exp_q[$];
    string phase = "init";
    int    n_vec = 0;
    int    n_miss = 0;

    up_counter_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .run_en   (run_en),
        .mode     (mode),
        .cfg_term (cfg_term),
        .irq_clr  (irq_clr),
        .count    (count),
        .busy     (busy),
        .wrap     (wrap),
        .done     (done),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] ec, input logic eb, input logic ew,
                       input logic ed, input logic ei);
        exp_t e;
        e.tag = phase;
        e.val = {ec, eb, ew, ed, ei};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t       mon_e;
    logic [7:0] mon_act;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e   = exp_q.pop_front();
                mon_act = {count, busy, wrap, done, irq};
                n_vec++;
                if (mon_act !== mon_e.val) begin
                    n_miss++;
                    $display("FAIL %s @%0t: got cnt=%0d busy=%b wrap=%b done=%b irq=%b, want cnt=%0d busy=%b wrap=%b done=%b irq=%b",
                             mon_e.tag, $time, mon_act[7:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                             mon_e.val[7:4], mon_e.val[3], mon_e.val[2], mon_e.val[1], mon_e.val[0]);
                end
            end
        end
    end

    initial begin
        @(negedge clk);

        // Reset held 3 edges, then idle 5 edges with no start.
        phase = "reset";
        rst = 1'b1;
        repeat (3) cyc(4'd0, 0, 0, 0, 0);
        rst = 1'b0;
        phase = "idle";
        repeat (5) cyc(4'd0, 0, 0, 0, 0);

        // One-shot, term=5: count 0..5, done one edge after reaching 5.
        phase = "oneshot";
        cfg_term = 4'd5; mode = 1'b0; run_en = 1'b1; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) cyc(4'(k), 1, 0, 0, 0);
        cyc(4'd5, 0, 0, 1, 1);
        repeat (2) cyc(4'd5, 0, 0, 0, 1);
        phase = "oneshot_irqclr";
        irq_clr = 1'b1;
        cyc(4'd5, 0, 0, 0, 0);
        irq_clr = 1'b0;
        cyc(4'd5, 0, 0, 0, 0);

        // Periodic, term=3, restarted from DONE.
        phase = "periodic";
        cfg_term = 4'd3; mode = 1'b1; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) cyc(4'(k), 1, 0, 0, 0);
        cyc(4'd0, 1, 1, 0, 1);
        cyc(4'd1, 1, 0, 0, 1);
        phase = "periodic_irqclr";
        irq_clr = 1'b1;
        cyc(4'd2, 1, 0, 0, 0);
        irq_clr = 1'b0;
        cyc(4'd3, 1, 0, 0, 0);
        phase = "periodic_set_beats_clr";
        irq_clr = 1'b1;
        cyc(4'd0, 1, 1, 0, 1);
        irq_clr = 1'b0;
        phase = "periodic_stop";
        stop = 1'b1;
        cyc(4'd0, 0, 0, 0, 1);
        stop = 1'b0;
        irq_clr = 1'b1;
        cyc(4'd0, 0, 0, 0, 0);
        irq_clr = 1'b0;

        // Pause at count 4: run_en low across two edges, plus one edge to
        // re-enter RUN, so done slips three cycles.
        phase = "pause";
        cfg_term = 4'd9; mode = 1'b0; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) cyc(4'(k), 1, 0, 0, 0);
        run_en = 1'b0;
        repeat (2) cyc(4'd4, 1, 0, 0, 0);
        run_en = 1'b1;
        cyc(4'd4, 1, 0, 0, 0);
        for (int k = 5; k <= 9; k++) cyc(4'(k), 1, 0, 0, 0);
        cyc(4'd9, 0, 0, 1, 1);
        irq_clr = 1'b1;
        cyc(4'd9, 0, 0, 0, 0);
        irq_clr = 1'b0;

        // Conflicts: start while running ignored, cfg changes ignored,
        // start+stop together aborts.
        phase = "conflict";
        cfg_term = 4'd7; mode = 1'b0; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        cyc(4'd1, 1, 0, 0, 0);
        start = 1'b1; cfg_term = 4'd2; mode = 1'b1;
        cyc(4'd2, 1, 0, 0, 0);
        start = 1'b0;
        cyc(4'd3, 1, 0, 0, 0);
        cyc(4'd4, 1, 0, 0, 0);
        phase = "start_stop";
        start = 1'b1; stop = 1'b1;
        cyc(4'd0, 0, 0, 0, 0);
        start = 1'b0; stop = 1'b0;
        repeat (2) cyc(4'd0, 0, 0, 0, 0);

        // term=0 one-shot: done on the edge after the first RUN edge.
        phase = "term0_oneshot";
        cfg_term = 4'd0; mode = 1'b0; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        cyc(4'd0, 0, 0, 1, 1);
        cyc(4'd0, 0, 0, 0, 1);
        irq_clr = 1'b1;
        cyc(4'd0, 0, 0, 0, 0);
        irq_clr = 1'b0;

        // term=0 periodic: wrap every counting edge, count stays 0.
        phase = "term0_periodic";
        mode = 1'b1; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        repeat (3) cyc(4'd0, 1, 1, 0, 1);
        stop = 1'b1;
        cyc(4'd0, 0, 0, 0, 1);
        stop = 1'b0;
        irq_clr = 1'b1;
        cyc(4'd0, 0, 0, 0, 0);
        irq_clr = 1'b0;

        // term=15 periodic: full range then wrap, reset mid-run.
        phase = "term15_periodic";
        cfg_term = 4'd15; start = 1'b1;
        cyc(4'd0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 15; k++) cyc(4'(k), 1, 0, 0, 0);
        cyc(4'd0, 1, 1, 0, 1);
        cyc(4'd1, 1, 0, 0, 1);
        cyc(4'd2, 1, 0, 0, 1);
        phase = "mid_run_reset";
        rst = 1'b1;
        cyc(4'd0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) cyc(4'd0, 0, 0, 0, 0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
